pc_sequencer: RTL

Fetch-side controller that owns the program counter and sequences the branch unit's redirect decision into the pipeline. Each cycle it selects the next PC (sequential PC+4, branch target, or hold), generates IF/ID and ID/EX flush strobes on a taken redirect, and handles stall, halt/resume and target-fault traps. It sits between the hazard unit, the EX-stage branch unit (which supplies `pc_sel`/`br_pc`) and instruction memory.

---
 rtl/pc_seq_pkg.sv | 20 ++
 rtl/sat_counter.sv | 22 ++
 rtl/pc_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    TRAP = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    MISALIGN = 2'd1,
    RANGE    = 2'd2
  } trap_cause_t;

  // Byte distance between consecutive instruction words.
  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
//   clk, rst_n : clock and async clear
//   en         : increment request, ignored once the count is all-ones
//   count      : current value (registered)
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side program counter sequencer: picks PC+4, branch target or hold,
// flushes IF/ID and ID/EX on a taken redirect, and handles stall, halt/resume
// and sticky target-fault traps.
//   stall, ex_valid, pc_sel, br_pc, halt, resume : control inputs
//   pc, fetch_valid                               : fetch request
//   flush_ifid, flush_idex                        : same-cycle squash strobes
//   trap, trap_cause, trap_pc                     : sticky fault record
//   redirect_cnt                                  : saturating redirect count
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             pc_sel,
  input  logic [31:0]      br_pc,
  input  logic             halt,
  input  logic             resume,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [31:0]      trap_pc,
  output logic [CNT_W-1:0] redirect_cnt
);

  seq_state_t      state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  trap_cause_t     cause_q, fault;
  logic [31:0]     trap_pc_q;
  logic            redirect, flush, cnt_en, capture;

  assign redirect = ex_valid & pc_sel & (state == RUN);

  // Target fault classification; misalignment outranks range.
  always_comb begin
    fault = NONE;
    if (br_pc[1:0] != 2'b00) begin
      fault = MISALIGN;
    end else if ((br_pc >> PC_W) != 32'd0) begin
      fault = RANGE;
    end
  end

  // Next state, next PC and strobes.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    flush     = 1'b0;
    cnt_en    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        // Halting instruction is older than the branch, so it wins.
        if (halt) begin
          state_nxt = HALT;
          flush     = 1'b1;
        end else if (redirect && (fault != NONE)) begin
          state_nxt = TRAP;
          flush     = 1'b1;
          capture   = 1'b1;
        end else if (redirect) begin
          pc_nxt = br_pc[PC_W-1:0];
          flush  = 1'b1;
          cnt_en = 1'b1;
        end else if (!stall) begin
          pc_nxt = pc + PC_W'(PC_INC);
        end
      end
      HALT: begin
        if (resume && !halt) begin
          state_nxt = RUN;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      cause_q   <= NONE;
      trap_pc_q <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (capture) begin
        cause_q   <= fault;
        trap_pc_q <= br_pc;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .count (redirect_cnt)
  );

  assign fetch_valid = (state == RUN);
  assign trap        = (state == TRAP);
  assign trap_cause  = cause_q;
  assign trap_pc     = trap_pc_q;
  assign flush_ifid  = flush;
  assign flush_idex  = flush;

endmodule
